// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: W stage has priority, LL results buffer and drain.
// Ports: clk/reset; W and LL write sources; scoreboard busy; GRF write port.
module grf_wport_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_wa,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_wa,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_wa,
    input  logic [31:0] ll_wd,
    input  logic [31:0] ll_pc,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        busy1,
    output logic        busy2,
    output logic        w_stall_req,
    output logic        issue_err,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        FORCE
    } state_t;

    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    state_t      state;
    logic [4:0]  buf_wa;
    logic [31:0] buf_wd;
    logic [31:0] buf_pc;
    logic [3:0]  wait_cnt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic w_act;
    logic buf_full;
    logic drain;
    logic accept;
    logic load;
    logic iss;

    assign w_act    = w_we & (w_wa != 5'd0);
    assign buf_full = (state != IDLE);
    assign drain    = buf_full & ~w_act;
    assign ll_ready = ~buf_full | drain;
    assign accept   = ll_valid & ll_ready;
    // Results for $0 are consumed but never buffered.
    assign load     = accept & (ll_wa != 5'd0);
    assign iss      = ll_issue & (ll_issue_wa != 5'd0);

    assign w_stall_req = (state == FORCE);

    // Port mux; reset suppresses any write while it is asserted.
    always_comb begin
        grf_we = 1'b0;
        grf_wa = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (!reset) begin
            if (w_act) begin
                grf_we = 1'b1;
                grf_wa = w_wa;
                grf_wd = w_wd;
                grf_pc = w_pc;
            end else if (drain) begin
                grf_we = 1'b1;
                grf_wa = buf_wa;
                grf_wd = buf_wd;
                grf_pc = buf_pc;
            end
        end
    end

    // A new reservation beats a drain to the same register.
    always_comb begin
        pending_nxt = pending;
        if (drain)
            pending_nxt[buf_wa] = 1'b0;
        if (iss)
            pending_nxt[ll_issue_wa] = 1'b1;
    end

    // The draining register is forwarded by the GRF, so readers need not stall.
    assign busy1 = (rd_a1 != 5'd0) & pending[rd_a1]
                 & ~(drain & (buf_wa == rd_a1));
    assign busy2 = (rd_a2 != 5'd0) & pending[rd_a2]
                 & ~(drain & (buf_wa == rd_a2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            buf_wa    <= 5'd0;
            buf_wd    <= 32'd0;
            buf_pc    <= 32'd0;
            wait_cnt  <= 4'd0;
            pending   <= 32'd0;
            issue_err <= 1'b0;
        end else begin
            if (load) begin
                buf_wa <= ll_wa;
                buf_wd <= ll_wd;
                buf_pc <= ll_pc;
            end
            unique case (state)
                IDLE: begin
                    wait_cnt <= 4'd0;
                    if (load)
                        state <= HELD;
                end
                HELD, FORCE: begin
                    if (drain) begin
                        wait_cnt <= 4'd0;
                        state    <= load ? HELD : IDLE;
                    end else begin
                        if (wait_cnt != WMAX)
                            wait_cnt <= wait_cnt + 4'd1;
                        // Escalate on the edge the count reaches the limit.
                        if ((wait_cnt + 4'd1) >= WMAX)
                            state <= FORCE;
                    end
                end
                default: state <= IDLE;
            endcase
            pending <= pending_nxt;
            if (iss & pending[ll_issue_wa]
                & ~(drain & (buf_wa == ll_issue_wa)))
                issue_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter (MAX_WAIT=4).
// Inputs change 1ns after posedge; outputs checked at negedge.
module tb_grf_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        ll_issue;
    logic [4:0]  ll_issue_wa;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_wa;
    logic [31:0] ll_wd;
    logic [31:0] ll_pc;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        busy1;
    logic        busy2;
    logic        w_stall_req;
    logic        issue_err;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grf_wport_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc),
        .ll_issue(ll_issue), .ll_issue_wa(ll_issue_wa),
        .ll_valid(ll_valid), .ll_ready(ll_ready),
        .ll_wa(ll_wa), .ll_wd(ll_wd), .ll_pc(ll_pc),
        .rd_a1(rd_a1), .rd_a2(rd_a2),
        .busy1(busy1), .busy2(busy2),
        .w_stall_req(w_stall_req), .issue_err(issue_err),
        .grf_we(grf_we), .grf_wa(grf_wa),
        .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        w_we = 0; w_wa = 0; w_wd = 0; w_pc = 0;
        ll_issue = 0; ll_issue_wa = 0;
        ll_valid = 0; ll_wa = 0; ll_wd = 0; ll_pc = 0;
        rd_a1 = 0; rd_a2 = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wdrv(input logic [4:0] a, input logic [31:0] d);
        w_we = 1; w_wa = a; w_wd = d; w_pc = 32'h200;
    endtask

    task automatic lldrv(input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p);
        ll_valid = 1; ll_wa = a; ll_wd = d; ll_pc = p;
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        sample();
        chk("rst_we", grf_we, 0);
        chk("rst_ready", ll_ready, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_stall", w_stall_req, 0);
        chk("rst_ierr", issue_err, 0);
        @(posedge clk); #1;
        reset = 0;

        // 1: single LL result to $5
        next(); ll_issue = 1; ll_issue_wa = 5; rd_a1 = 5;
        sample(); chk("t1_busy_pre", busy1, 0);
        next(); lldrv(5, 32'h12345678, 32'h100); rd_a1 = 5;
        sample();
        chk("t1_ready", ll_ready, 1);
        chk("t1_busy", busy1, 1);
        chk("t1_we0", grf_we, 0);
        next(); rd_a1 = 5;
        sample();
        chk("t1_we", grf_we, 1);
        chk("t1_wa", grf_wa, 5);
        chk("t1_wd", grf_wd, 32'h12345678);
        chk("t1_pc", grf_pc, 32'h100);
        chk("t1_busy_drain", busy1, 0);
        next(); rd_a1 = 5;
        sample();
        chk("t1_idle_we", grf_we, 0);
        chk("t1_busy_post", busy1, 0);

        // 2: LL result starved by W writes to $3
        next(); lldrv(7, 32'hA7, 32'h104); wdrv(3, 32'h33);
        sample();
        chk("t2_acc_ready", ll_ready, 1);
        chk("t2_acc_wa", grf_wa, 3);
        for (int k = 1; k <= 6; k++) begin
            next(); wdrv(3, 32'h30 + k);
            sample();
            chk($sformatf("t2_wa_%0d", k), grf_wa, 3);
            chk($sformatf("t2_wd_%0d", k), grf_wd, 32'h30 + k);
            chk($sformatf("t2_ready_%0d", k), ll_ready, 0);
            chk($sformatf("t2_stall_%0d", k), w_stall_req, (k >= 5) ? 1 : 0);
        end
        next();
        sample();
        chk("t2_drain_we", grf_we, 1);
        chk("t2_drain_wa", grf_wa, 7);
        chk("t2_drain_wd", grf_wd, 32'hA7);
        next();
        sample();
        chk("t2_post_stall", w_stall_req, 0);
        chk("t2_post_we", grf_we, 0);

        // 3: back-to-back drain and accept, in order
        next(); lldrv(10, 32'hAA, 32'h110);
        next(); lldrv(11, 32'hBB, 32'h114); wdrv(4, 32'h44);
        sample();
        chk("t3_ready_blk", ll_ready, 0);
        chk("t3_w_wa", grf_wa, 4);
        next(); lldrv(11, 32'hBB, 32'h114);
        sample();
        chk("t3_ready_b2b", ll_ready, 1);
        chk("t3_first_wa", grf_wa, 10);
        chk("t3_first_wd", grf_wd, 32'hAA);
        next();
        sample();
        chk("t3_second_we", grf_we, 1);
        chk("t3_second_wa", grf_wa, 11);
        chk("t3_second_pc", grf_pc, 32'h114);
        next();
        sample();
        chk("t3_done_we", grf_we, 0);

        // 4: scoreboard busy on $8
        next(); ll_issue = 1; ll_issue_wa = 8;
        next(); rd_a1 = 8; rd_a2 = 0;
        sample();
        chk("t4_busy1", busy1, 1);
        chk("t4_busy2", busy2, 0);
        next(); lldrv(8, 32'h88, 32'h120); rd_a1 = 8;
        sample(); chk("t4_busy1_acc", busy1, 1);
        next(); rd_a1 = 8; rd_a2 = 0;
        sample();
        chk("t4_drain_wa", grf_wa, 8);
        chk("t4_busy1_drain", busy1, 0);
        chk("t4_busy2_drain", busy2, 0);
        next(); rd_a1 = 8;
        sample(); chk("t4_busy1_post", busy1, 0);
        chk("t4_ierr", issue_err, 0);

        // 5: double issue to $8
        next(); ll_issue = 1; ll_issue_wa = 8;
        next(); ll_issue = 1; ll_issue_wa = 8;
        sample(); chk("t5_ierr_pre", issue_err, 0);
        next();
        sample(); chk("t5_ierr", issue_err, 1);
        next(); lldrv(8, 32'h89, 32'h124);
        next();
        sample(); chk("t5_drain_wa", grf_wa, 8);
        next(); rd_a1 = 8;
        sample();
        chk("t5_ierr_sticky", issue_err, 1);
        chk("t5_busy_clear", busy1, 0);

        // $0 result is consumed and dropped
        next(); lldrv(0, 32'hDEAD, 32'h128);
        sample(); chk("z_ready", ll_ready, 1);
        next();
        sample();
        chk("z_we", grf_we, 0);
        chk("z_ready_post", ll_ready, 1);

        // 6: reset with buffer full and $9 pending
        next(); ll_issue = 1; ll_issue_wa = 9;
        next(); lldrv(9, 32'h99, 32'h130); wdrv(2, 32'h22);
        next(); wdrv(2, 32'h23); rd_a1 = 9;
        sample();
        chk("t6_busy_pre", busy1, 1);
        chk("t6_ready_pre", ll_ready, 0);
        #1 reset = 1;
        #1;
        chk("t6_rst_we", grf_we, 0);
        chk("t6_rst_ready", ll_ready, 1);
        chk("t6_rst_stall", w_stall_req, 0);
        chk("t6_rst_busy", busy1, 0);
        chk("t6_rst_ierr", issue_err, 0);
        next(); reset = 0; rd_a1 = 9;
        sample();
        chk("t6_post_we", grf_we, 0);
        chk("t6_post_busy", busy1, 0);
        chk("t6_post_ready", ll_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
